// File: rtl/fb_fill_if.sv
// Command and framebuffer-bus bundle for fb_fill_master.
// CMD_OUTLINE is present only when FB_FILL_OUTLINE_EN is defined.
interface fb_fill_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [5:0]  CMD_X;
  logic [5:0]  CMD_Y;
  logic [6:0]  CMD_W;
  logic [6:0]  CMD_H;
  logic [2:0]  CMD_COLOR;
  logic        CMD_SWAP;
`ifdef FB_FILL_OUTLINE_EN
  logic        CMD_OUTLINE;
`endif
  logic        VSYNC;
  logic        CE;
  logic        RW;
  logic [14:0] ADDR;
  logic [6:0]  DATA;
  logic        BUSY;

  modport master (
`ifdef FB_FILL_OUTLINE_EN
    input  CMD_OUTLINE,
`endif
    input  CMD_VALID, CMD_X, CMD_Y, CMD_W, CMD_H, CMD_COLOR, CMD_SWAP, VSYNC,
    output CMD_READY, CE, RW, ADDR, DATA, BUSY
  );

  modport slave (
`ifdef FB_FILL_OUTLINE_EN
    output CMD_OUTLINE,
`endif
    output CMD_VALID, CMD_X, CMD_Y, CMD_W, CMD_H, CMD_COLOR, CMD_SWAP, VSYNC,
    input  CMD_READY, CE, RW, ADDR, DATA, BUSY
  );
endinterface

// File: rtl/fb_fill_master.sv
// Framebuffer rectangle-fill bus master with optional vsync-aligned buffer swap.
// Optional outline-only fills are enabled by defining FB_FILL_OUTLINE_EN.
module fb_fill_master #(
  parameter int unsigned FB_WIDTH  = 64,
  parameter int unsigned FB_HEIGHT = 48,
  parameter int unsigned FB_BASE   = 4096
) (
  input logic       CLK,
  input logic       RST,
  fb_fill_if.master bus
);

  localparam logic [7:0] FbW = 8'(FB_WIDTH);
  localparam logic [7:0] FbH = 8'(FB_HEIGHT);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StGap,
    StSwapWait,
    StSwap,
    StSwapGap
  } state_e;

  state_e      r_state;
  logic        r_ready;
  logic        r_busy;
  logic        r_ce;
  logic        r_rw;
  logic [14:0] r_addr;
  logic [6:0]  r_data;
  logic [7:0]  r_x;
  logic [7:0]  r_y;
  logic [7:0]  r_x0;
  logic [7:0]  r_y0;
  logic [7:0]  r_xe;
  logic [7:0]  r_ye;
  logic [2:0]  r_color;
  logic        r_swap;
  logic        r_armed;
`ifdef FB_FILL_OUTLINE_EN
  logic        r_outline;
`endif
  logic        r_vs_s1;
  logic        r_vs_s2;
  logic        r_vs_d;

  logic [7:0]  w_xe_sum;
  logic [7:0]  w_ye_sum;
  logic [7:0]  w_xe;
  logic [7:0]  w_ye;
  logic        w_empty;
  logic        w_interior;
  logic        w_row_end;
  logic        w_done;
  logic [7:0]  w_nx;
  logic [7:0]  w_ny;
  logic        w_fall;

  function automatic logic [14:0] pix_addr(input logic [7:0] px, input logic [7:0] py);
    return 15'(FB_BASE + 32'(py) * FB_WIDTH + 32'(px));
  endfunction

  // Clip the offered rectangle against the framebuffer.
  always_comb begin
    w_xe_sum = {2'b00, bus.CMD_X} + {1'b0, bus.CMD_W};
    w_ye_sum = {2'b00, bus.CMD_Y} + {1'b0, bus.CMD_H};
    w_xe     = (w_xe_sum > FbW) ? FbW : w_xe_sum;
    w_ye     = (w_ye_sum > FbH) ? FbH : w_ye_sum;
    w_empty  = ({2'b00, bus.CMD_X} >= FbW) || ({2'b00, bus.CMD_Y} >= FbH) ||
               (bus.CMD_W == 7'd0) || (bus.CMD_H == 7'd0);
  end

  // Raster advance; outline interior rows skip straight to the right border.
  always_comb begin
    w_interior = 1'b0;
`ifdef FB_FILL_OUTLINE_EN
    w_interior = r_outline && (r_y != r_y0) && (r_y != r_ye - 8'd1);
`endif
    w_row_end = (r_x + 8'd1 == r_xe);
    w_nx      = r_x + 8'd1;
    w_ny      = r_y;
    if (w_interior && (r_x == r_x0) && !w_row_end) begin
      w_nx = r_xe - 8'd1;
    end
    if (w_row_end) begin
      w_nx = r_x0;
      w_ny = r_y + 8'd1;
    end
    w_done = w_row_end && (r_y + 8'd1 == r_ye);
  end

  assign w_fall = r_vs_d & ~r_vs_s2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vs_s1 <= 1'b1;
      r_vs_s2 <= 1'b1;
      r_vs_d  <= 1'b1;
    end else begin
      r_vs_s1 <= bus.VSYNC;
      r_vs_s2 <= r_vs_s1;
      r_vs_d  <= r_vs_s2;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= StIdle;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_ce      <= 1'b1;
      r_rw      <= 1'b1;
      r_addr    <= '0;
      r_data    <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_x0      <= '0;
      r_y0      <= '0;
      r_xe      <= '0;
      r_ye      <= '0;
      r_color   <= '0;
      r_swap    <= 1'b0;
      r_armed   <= 1'b0;
`ifdef FB_FILL_OUTLINE_EN
      r_outline <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.CMD_VALID) begin
            r_color <= bus.CMD_COLOR;
            r_swap  <= bus.CMD_SWAP;
            r_x     <= {2'b00, bus.CMD_X};
            r_y     <= {2'b00, bus.CMD_Y};
            r_x0    <= {2'b00, bus.CMD_X};
            r_y0    <= {2'b00, bus.CMD_Y};
            r_xe    <= w_xe;
            r_ye    <= w_ye;
`ifdef FB_FILL_OUTLINE_EN
            r_outline <= bus.CMD_OUTLINE;
`endif
            if (!w_empty) begin
              r_state <= StWr;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
              r_ce    <= 1'b0;
              r_rw    <= 1'b0;
              r_addr  <= pix_addr({2'b00, bus.CMD_X}, {2'b00, bus.CMD_Y});
              r_data  <= {4'b0000, bus.CMD_COLOR};
            end else if (bus.CMD_SWAP) begin
              r_state <= StSwapWait;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
              r_armed <= 1'b0;
            end
          end
        end
        StWr: begin
          r_state <= StGap;
          r_ce    <= 1'b1;
          r_rw    <= 1'b1;
        end
        StGap: begin
          r_x <= w_nx;
          r_y <= w_ny;
          if (!w_done) begin
            r_state <= StWr;
            r_ce    <= 1'b0;
            r_rw    <= 1'b0;
            r_addr  <= pix_addr(w_nx, w_ny);
            r_data  <= {4'b0000, r_color};
          end else if (r_swap) begin
            r_state <= StSwapWait;
            r_armed <= 1'b0;
          end else begin
            r_state <= StIdle;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        StSwapWait: begin
          // Only a fall from a high level seen inside this wait counts.
          if (r_vs_s2) begin
            r_armed <= 1'b1;
          end
          if (r_armed && w_fall) begin
            r_state <= StSwap;
            r_ce    <= 1'b0;
            r_rw    <= 1'b0;
            r_addr  <= 15'(FB_BASE);
            r_data  <= 7'b1000000;
          end
        end
        StSwap: begin
          r_state <= StSwapGap;
          r_ce    <= 1'b1;
          r_rw    <= 1'b1;
        end
        StSwapGap: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_ce    <= 1'b1;
          r_rw    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.CMD_READY = r_ready;
  assign bus.BUSY      = r_busy;
  assign bus.CE        = r_ce;
  assign bus.RW        = r_rw;
  assign bus.ADDR      = r_addr;
  assign bus.DATA      = r_data;

endmodule
